// File: rtl/trinary_pkg.sv
// Shared trit code and assembler state definitions.
// Used by the resolver and word assembler stages.
package trinary_pkg;

   typedef enum logic [1:0] {
      POSITIVE = 2'b00,
      NEGATIVE = 2'b01,
      UNSTABLE = 2'b10,
      ILLEGAL  = 2'b11
   } trit_code_e;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } asm_state_e;

endpackage

// File: rtl/trit_digit_decode.sv
// Maps a raw trit code to a signed balanced-ternary digit
// plus unstable/illegal classification flags.
module trit_digit_decode
   import trinary_pkg::*;
(
   input  logic [1:0]        code_i,
   output logic signed [1:0] digit_o,
   output logic              is_unstable_o,
   output logic              is_illegal_o
);

   always_comb begin
      digit_o       = 2'sb00;
      is_unstable_o = 1'b0;
      is_illegal_o  = 1'b0;
      unique case (trit_code_e'(code_i))
         POSITIVE: digit_o       = 2'sb01;
         NEGATIVE: digit_o       = 2'sb11;
         UNSTABLE: is_unstable_o = 1'b1;
         ILLEGAL:  is_illegal_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/trit_word_assembler.sv
// Packs resolved trits (LSB first) into a word with its signed
// balanced-ternary value; aborts partial words on long stalls.
module trit_word_assembler
   import trinary_pkg::*;
#(
   parameter int NUM_TRITS   = 4,
   parameter int STALL_LIMIT = 15,
   parameter int VALUE_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [1:0]                 in_trit,
   output logic                       in_ready,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [2*NUM_TRITS-1:0]     word_trits,
   output logic signed [VALUE_W-1:0]  word_value,
   output logic                       err_timeout,
   output logic                       err_illegal,
   input  logic                       err_clr
);

   localparam int CW = $clog2(NUM_TRITS + 1);
   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int WW = VALUE_W + 2;

   asm_state_e                state_q;
   logic [CW-1:0]             count_q, count_d;
   logic [SW-1:0]             stall_q, stall_d;
   logic [WW-1:0]             weight_q;
   logic signed [VALUE_W-1:0] value_q, value_d;
   logic [2*NUM_TRITS-1:0]    trits_q;
   logic                      err_to_q, err_il_q;

   logic signed [1:0] digit;
   logic              is_unstable;
   logic              is_illegal;

   trit_digit_decode u_dec (
      .code_i        (in_trit),
      .digit_o       (digit),
      .is_unstable_o (is_unstable),
      .is_illegal_o  (is_illegal)
   );

   always_comb begin
      count_d = count_q + CW'(1);
      stall_d = stall_q + SW'(1);
      // weight is unsigned, so zero-extend before the signed multiply
      value_d = VALUE_W'(value_q + digit * $signed({1'b0, weight_q}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         count_q  <= '0;
         stall_q  <= '0;
         weight_q <= WW'(1);
         value_q  <= '0;
         trits_q  <= '0;
         err_to_q <= 1'b0;
         err_il_q <= 1'b0;
      end else begin
         if (err_clr) begin
            err_to_q <= 1'b0;
            err_il_q <= 1'b0;
         end
         unique case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  if (is_illegal) begin
                     err_il_q <= 1'b1;
                  end else if (is_unstable) begin
                     if (count_q != '0) begin
                        if (stall_d == SW'(STALL_LIMIT)) begin
                           count_q  <= '0;
                           stall_q  <= '0;
                           weight_q <= WW'(1);
                           value_q  <= '0;
                           trits_q  <= '0;
                           err_to_q <= 1'b1;
                        end else begin
                           stall_q <= stall_d;
                        end
                     end
                  end else begin
                     for (int i = 0; i < NUM_TRITS; i++) begin
                        if (count_q == CW'(i)) trits_q[2*i +: 2] <= in_trit;
                     end
                     value_q  <= value_d;
                     weight_q <= weight_q * WW'(3);
                     count_q  <= count_d;
                     stall_q  <= '0;
                     if (count_d == CW'(NUM_TRITS)) state_q <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (word_ready) begin
                  state_q  <= COLLECT;
                  count_q  <= '0;
                  stall_q  <= '0;
                  weight_q <= WW'(1);
                  value_q  <= '0;
                  trits_q  <= '0;
               end
            end
         endcase
      end
   end

   assign in_ready    = (state_q == COLLECT);
   assign word_valid  = (state_q == EMIT);
   assign word_trits  = trits_q;
   assign word_value  = value_q;
   assign err_timeout = err_to_q;
   assign err_illegal = err_il_q;

endmodule

// File: tb/tb_trit_word_assembler.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic against a digit-list reference model.
module tb_trit_word_assembler;

   localparam int N  = 4;
   localparam int SL = 15;
   localparam int VW = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [1:0]        in_trit = 2'b00;
   logic              in_ready;
   logic              word_valid;
   logic              word_ready = 1'b0;
   logic [2*N-1:0]    word_trits;
   logic signed [VW-1:0] word_value;
   logic              err_timeout;
   logic              err_illegal;
   logic              err_clr = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   trit_word_assembler #(
      .NUM_TRITS   (N),
      .STALL_LIMIT (SL),
      .VALUE_W     (VW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_trit     (in_trit),
      .in_ready    (in_ready),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_trits  (word_trits),
      .word_value  (word_value),
      .err_timeout (err_timeout),
      .err_illegal (err_illegal),
      .err_clr     (err_clr)
   );

   // reference model: accepted digits (+1/-1) in arrival order
   bit m_emit = 1'b0;
   int m_q[$];
   int m_stall = 0;
   bit m_eto = 1'b0;
   bit m_eil = 1'b0;

   function automatic int m_value();
      int s = 0;
      int w = 1;
      foreach (m_q[i]) begin
         s += m_q[i] * w;
         w *= 3;
      end
      return s;
   endfunction

   function automatic logic [2*N-1:0] m_trits();
      logic [2*N-1:0] t = '0;
      foreach (m_q[i]) t[2*i +: 2] = (m_q[i] > 0) ? 2'b00 : 2'b01;
      return t;
   endfunction

   task automatic model_step(input bit v, input logic [1:0] t,
                             input bit wr, input bit clr, input bit r);
      if (r) begin
         m_emit = 0; m_q.delete(); m_stall = 0; m_eto = 0; m_eil = 0;
         return;
      end
      if (clr) begin
         m_eto = 0; m_eil = 0;
      end
      if (!m_emit) begin
         if (v) begin
            if (t == 2'b11) begin
               m_eil = 1;
            end else if (t == 2'b10) begin
               if (m_q.size() > 0) begin
                  m_stall++;
                  if (m_stall == SL) begin
                     m_q.delete(); m_stall = 0; m_eto = 1;
                  end
               end
            end else begin
               m_q.push_back(t == 2'b00 ? 1 : -1);
               m_stall = 0;
               if (m_q.size() == N) m_emit = 1;
            end
         end
      end else if (wr) begin
         m_emit = 0; m_q.delete(); m_stall = 0;
      end
   endtask

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit v, input logic [1:0] t,
                      input bit wr, input bit clr, input bit r);
      in_valid = v; in_trit = t; word_ready = wr; err_clr = clr; rst = r;
      @(posedge clk);
      #1;
      model_step(v, t, wr, clr, r);
      chk("in_ready", 32'(in_ready), 32'(!m_emit));
      chk("word_valid", 32'(word_valid), 32'(m_emit));
      chk("err_timeout", 32'(err_timeout), 32'(m_eto));
      chk("err_illegal", 32'(err_illegal), 32'(m_eil));
      if (m_emit) begin
         chk("word_value", 32'(word_value), m_value());
         chk("word_trits", 32'(word_trits), 32'(m_trits()));
      end
   endtask

   task automatic feed(input logic [2*N-1:0] w, input bit wr);
      for (int k = 0; k < N; k++) cyc(1, w[2*k +: 2], wr, 0, 0);
   endtask

   typedef struct {
      logic [2*N-1:0] trits;
      int             val;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{8'b00_00_01_00,  34};
      tbl[1] = '{8'b01_01_01_01, -40};
      tbl[2] = '{8'b00_00_00_00,  40};
      tbl[3] = '{8'b00_01_00_01,  20};
      tbl[4] = '{8'b01_00_01_00, -20};

      cyc(0, 2'b00, 0, 0, 1);
      chk("rst_trits", 32'(word_trits), 0);
      chk("rst_value", 32'(word_value), 0);
      chk("rst_ready", 32'(in_ready), 1);

      foreach (tbl[i]) begin
         cyc(0, 2'b00, 0, 0, 1);
         feed(tbl[i].trits, 1);
         chk("tbl_valid", 32'(word_valid), 1);
         chk("tbl_value", 32'(word_value), tbl[i].val);
         chk("tbl_trits", 32'(word_trits), 32'(tbl[i].trits));
         cyc(0, 2'b00, 1, 0, 0);
         chk("tbl_ready", 32'(in_ready), 1);
      end

      // stall timeout, then a clean word
      cyc(0, 2'b00, 0, 0, 1);
      cyc(1, 2'b00, 1, 0, 0);
      for (int k = 0; k < SL; k++) cyc(1, 2'b10, 1, 0, 0);
      chk("to_flag", 32'(err_timeout), 1);
      feed(8'h00, 1);
      chk("to_value", 32'(word_value), 40);
      cyc(0, 2'b00, 1, 0, 0);

      // idle cycles do not touch the stall count
      cyc(1, 2'b01, 1, 1, 0);
      for (int k = 0; k < SL - 1; k++) cyc(1, 2'b10, 1, 0, 0);
      for (int k = 0; k < 5; k++) cyc(0, 2'b10, 1, 0, 0);
      chk("idle_noto", 32'(err_timeout), 0);
      cyc(1, 2'b10, 1, 0, 0);
      chk("idle_to", 32'(err_timeout), 1);

      // backpressure: hold for 10 cycles, then release
      cyc(0, 2'b00, 0, 0, 1);
      feed(8'h00, 0);
      for (int k = 0; k < 10; k++) begin
         cyc(1, 2'b01, 0, 0, 0);
         chk("bp_value", 32'(word_value), 40);
         chk("bp_ready", 32'(in_ready), 0);
      end
      cyc(1, 2'b01, 1, 0, 0);
      chk("bp_release", 32'(in_ready), 1);
      feed(8'h00, 1);
      chk("bp_next", 32'(word_value), 40);
      cyc(0, 2'b00, 1, 0, 0);

      // illegal code with simultaneous clear: set wins
      cyc(1, 2'b00, 1, 0, 0);
      cyc(1, 2'b11, 1, 1, 0);
      chk("il_flag", 32'(err_illegal), 1);
      cyc(1, 2'b01, 1, 0, 0);
      cyc(1, 2'b00, 1, 0, 0);
      cyc(1, 2'b00, 1, 0, 0);
      chk("il_value", 32'(word_value), 34);
      cyc(0, 2'b00, 1, 1, 0);
      chk("il_clr", 32'(err_illegal), 0);

      // reset mid-word and during EMIT
      cyc(1, 2'b11, 1, 0, 0);
      cyc(1, 2'b00, 1, 0, 0);
      cyc(1, 2'b01, 1, 0, 0);
      cyc(1, 2'b00, 1, 0, 1);
      chk("rmid_value", 32'(word_value), 0);
      chk("rmid_trits", 32'(word_trits), 0);
      chk("rmid_il", 32'(err_illegal), 0);
      feed(8'b01_01_01_01, 0);
      cyc(1, 2'b00, 0, 0, 1);
      chk("remit_valid", 32'(word_valid), 0);
      chk("remit_ready", 32'(in_ready), 1);
      chk("remit_trits", 32'(word_trits), 0);
      chk("remit_value", 32'(word_value), 0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         bit v, wr, clr, r;
         logic [1:0] t;
         int sel;
         v   = ($urandom % 4) != 0;
         wr  = ($urandom % 3) != 0;
         clr = ($urandom % 40) == 0;
         r   = ($urandom % 600) == 0;
         sel = $urandom % 16;
         if (((n / 64) % 4) == 3) t = (sel < 14) ? 2'b10 : 2'b00;
         else if (sel < 6) t = 2'b00;
         else if (sel < 12) t = 2'b01;
         else if (sel < 15) t = 2'b10;
         else t = 2'b11;
         cyc(v, t, wr, clr, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
